// File: rtl/pe_ctrl_pkg.sv
// pe_ctrl_pkg: shared declarations for the Life PE array sequencer.
//   - ctrl_state_t : controller state encoding (IDLE/LOAD/RUN/READ)
//   - row_idx_w / col_idx_w : index widths for the scan pointer
// The PE command codes and the PE state width normally arrive from the PE
// array declaration header; the guarded fallbacks below only apply when that
// header has not been read ahead of this file.
`ifndef PE_CMD_BITS
`define PE_CMD_BITS 2
`endif
`ifndef PE_CMD_NOP
`define PE_CMD_NOP 2'd0
`endif
`ifndef PE_CMD_WRITE
`define PE_CMD_WRITE 2'd1
`endif
`ifndef PE_CMD_PROCESS
`define PE_CMD_PROCESS 2'd2
`endif
`ifndef PE_STATE_BITS
`define PE_STATE_BITS 1
`endif

package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_READ = 2'd3
    } ctrl_state_t;

    function automatic int unsigned row_idx_w(input int unsigned rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int unsigned col_idx_w(input int unsigned cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// pe_array_ctrl_if: host streams and PE array bus around the sequencer.
//   load_valid/load_ready/load_state : pattern load stream (host -> ctrl)
//   rd_valid/rd_ready/rd_state       : board readout stream (ctrl -> host)
//   cmd, rsel_i/csel_i, state_in     : broadcast command and write port
//   rsel_o/csel_o                    : read selects
//   array_state_out, any_active      : OR-reduced array feedback
// modport master: the sequencer side; modport slave: host plus array side.
interface pe_array_ctrl_if #(
    parameter int unsigned ROWS = 16,
    parameter int unsigned COLS = 16
);
    logic                      load_valid;
    logic                      load_ready;
    logic [`PE_STATE_BITS-1:0] load_state;
    logic                      rd_valid;
    logic                      rd_ready;
    logic [`PE_STATE_BITS-1:0] rd_state;
    logic [`PE_CMD_BITS-1:0]   cmd;
    logic [ROWS-1:0]           rsel_i;
    logic [COLS-1:0]           csel_i;
    logic [ROWS-1:0]           rsel_o;
    logic [COLS-1:0]           csel_o;
    logic [`PE_STATE_BITS-1:0] state_in;
    logic [`PE_STATE_BITS-1:0] array_state_out;
    logic                      any_active;

    modport master (
        input  load_valid, load_state, rd_ready, array_state_out, any_active,
        output load_ready, rd_valid, rd_state, cmd,
               rsel_i, csel_i, rsel_o, csel_o, state_in
    );

    modport slave (
        output load_valid, load_state, rd_ready, array_state_out, any_active,
        input  load_ready, rd_valid, rd_state, cmd,
               rsel_i, csel_i, rsel_o, csel_o, state_in
    );
endinterface

// File: rtl/pe_scan_counter.sv
// pe_scan_counter: row-major (r,c) pointer shared by LOAD and READ.
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : return pointer to (0,0)
//   adv        : step pointer (column first, then row)
//   row_sel    : one-hot row decode of the pointer
//   col_sel    : one-hot column decode of the pointer
//   last       : pointer is at (ROWS-1, COLS-1)
module pe_scan_counter
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ROWS = 16,
    parameter int unsigned COLS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_sel,
    output logic            last
);
    localparam int unsigned RW = row_idx_w(ROWS);
    localparam int unsigned CW = col_idx_w(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0] row;
    logic [CW-1:0] col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        row_sel = '0;
        col_sel = '0;
        for (int unsigned i = 0; i < ROWS; i++) row_sel[i] = (row == RW'(i));
        for (int unsigned j = 0; j < COLS; j++) col_sel[j] = (col == CW'(j));
    end
endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequencer for the Life PE array (load / run / read).
//   clk, rst                  : clock, asynchronous active-low reset
//   op_load, op_run, op_read  : start pulses, honoured only in IDLE
//   num_gens                  : generation limit, latched when a run starts
//   bus (master)              : load/readout streams and PE array bus
//   busy                      : controller not in IDLE
//   done                      : one-cycle pulse on return to IDLE
//   stable                    : last run stopped on a no-change generation
//   gen_count                 : generations processed in current/last run
module pe_array_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_load,
    input  logic             op_run,
    input  logic             op_read,
    input  logic [GEN_W-1:0] num_gens,
    pe_array_ctrl_if.master  bus,
    output logic             busy,
    output logic             done,
    output logic             stable,
    output logic [GEN_W-1:0] gen_count
);
    ctrl_state_t      state, state_next;
    logic [GEN_W-1:0] limit;
    logic             scan_clr, scan_adv, scan_last;
    logic [ROWS-1:0]  scan_rsel;
    logic [COLS-1:0]  scan_csel;
    logic             process_cycle, run_start;

    // Pointer sits at (0,0) whenever idle, so every LOAD/READ starts there.
    assign scan_clr = (state == ST_IDLE);
    assign scan_adv = ((state == ST_LOAD) && bus.load_valid) ||
                      ((state == ST_READ) && bus.rd_ready);

    pe_scan_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_scan (
        .clk     (clk),
        .rst     (rst),
        .clr     (scan_clr),
        .adv     (scan_adv),
        .row_sel (scan_rsel),
        .col_sel (scan_csel),
        .last    (scan_last)
    );

    // A zero limit spends its single RUN cycle without issuing PROCESS.
    assign process_cycle = (state == ST_RUN) && (limit != '0);
    assign run_start     = (state == ST_IDLE) && (state_next == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if      (op_load) state_next = ST_LOAD;
                else if (op_run)  state_next = ST_RUN;
                else if (op_read) state_next = ST_READ;
            end
            ST_LOAD: if (bus.load_valid && scan_last) state_next = ST_IDLE;
            ST_RUN: begin
                if (limit == '0 || !bus.any_active || gen_count == limit - 1'b1)
                    state_next = ST_IDLE;
            end
            ST_READ: if (bus.rd_ready && scan_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd        = `PE_CMD_NOP;
        bus.rsel_i     = '0;
        bus.csel_i     = '0;
        bus.rsel_o     = '0;
        bus.csel_o     = '0;
        bus.state_in   = '0;
        bus.load_ready = 1'b0;
        bus.rd_valid   = 1'b0;
        bus.rd_state   = '0;
        busy           = (state != ST_IDLE);
        unique case (state)
            ST_LOAD: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    bus.cmd      = `PE_CMD_WRITE;
                    bus.rsel_i   = scan_rsel;
                    bus.csel_i   = scan_csel;
                    bus.state_in = bus.load_state;
                end
            end
            ST_RUN: if (process_cycle) bus.cmd = `PE_CMD_PROCESS;
            ST_READ: begin
                bus.rd_valid = 1'b1;
                bus.rsel_o   = scan_rsel;
                bus.csel_o   = scan_csel;
                bus.rd_state = bus.array_state_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            stable    <= 1'b0;
            gen_count <= '0;
            limit     <= '0;
        end else begin
            done <= (state != ST_IDLE) && (state_next == ST_IDLE);
            if (run_start) begin
                gen_count <= '0;
                stable    <= 1'b0;
                limit     <= num_gens;
            end else if (process_cycle) begin
                gen_count <= gen_count + 1'b1;
                if (!bus.any_active) stable <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: scoreboard bench for pe_array_ctrl on a 4x4 array.
// A behavioural 4x4 Life array (dead boundary) answers the command bus;
// expected writes and read beats are queued as stimulus is driven and
// retired by a negedge monitor.
`ifndef PE_CMD_BITS
`define PE_CMD_BITS 2
`endif
`ifndef PE_CMD_NOP
`define PE_CMD_NOP 2'd0
`endif
`ifndef PE_CMD_WRITE
`define PE_CMD_WRITE 2'd1
`endif
`ifndef PE_CMD_PROCESS
`define PE_CMD_PROCESS 2'd2
`endif
`ifndef PE_STATE_BITS
`define PE_STATE_BITS 1
`endif

module tb_pe_array_ctrl;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned GEN_W = 16;
    localparam logic [15:0] PAT_BLINK = 16'h0070;  // row 1, cols 0..2
    localparam logic [15:0] PAT_BLOCK = 16'h0660;  // 2x2 at (1,1)
    localparam logic [15:0] PAT_A     = 16'hA5C3;

    typedef struct {
        int unsigned r;
        int unsigned c;
        logic        st;
    } cell_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             op_load = 1'b0, op_run = 1'b0, op_read = 1'b0;
    logic [GEN_W-1:0] num_gens = '0;
    logic             busy, done, stable;
    logic [GEN_W-1:0] gen_count;

    pe_array_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    pe_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_load   (op_load),
        .op_run    (op_run),
        .op_read   (op_read),
        .num_gens  (num_gens),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .stable    (stable),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int write_cnt = 0, proc_cnt = 0, read_cnt = 0;
    int last_proc_cyc = 0, last_xfer_cyc = 0;
    cell_t load_q[$];
    cell_t read_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- behavioural 4x4 Life array ----------------
    logic [15:0] board = '0;

    function automatic logic [15:0] life_next(input logic [15:0] b);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int cnt;
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 4 &&
                            c + dc >= 0 && c + dc < 4 && b[(r + dr) * 4 + c + dc])
                            cnt++;
                n[r * 4 + c] = b[r * 4 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
            end
        end
        return n;
    endfunction

    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                acc = acc | (bus.rsel_o[r] & bus.csel_o[c] & board[r * 4 + c]);
        bus.array_state_out = `PE_STATE_BITS'(acc);
        bus.any_active      = |(life_next(board) ^ board);
    end

    always @(posedge clk) begin
        if (bus.cmd == `PE_CMD_WRITE) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (bus.rsel_i[r] && bus.csel_i[c]) board[r * 4 + c] <= bus.state_in[0];
        end else if (bus.cmd == `PE_CMD_PROCESS) begin
            board <= life_next(board);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.cmd == `PE_CMD_WRITE) begin
                write_cnt++;
                if (load_q.size() == 0) begin
                    check_eq("write_unexpected", 32'(bus.rsel_i), 32'd0);
                end else begin
                    cell_t e;
                    e = load_q.pop_front();
                    check_eq("write_rsel", 32'(bus.rsel_i), 32'(1) << e.r);
                    check_eq("write_csel", 32'(bus.csel_i), 32'(1) << e.c);
                    check_eq("write_data", 32'(bus.state_in), 32'(e.st));
                end
            end
            if (bus.cmd == `PE_CMD_PROCESS) begin
                if (proc_cnt > 0) check_eq("process_back_to_back", 32'(cyc), 32'(last_proc_cyc + 1));
                proc_cnt++;
                last_proc_cyc = cyc;
            end
            if (bus.rd_valid === 1'b1) begin
                if (read_q.size() == 0) begin
                    check_eq("read_unexpected", 32'(bus.rd_valid), 32'd0);
                end else begin
                    check_eq("read_rsel", 32'(bus.rsel_o), 32'(1) << read_q[0].r);
                    check_eq("read_csel", 32'(bus.csel_o), 32'(1) << read_q[0].c);
                    if (bus.rd_ready) begin
                        cell_t e;
                        e = read_q.pop_front();
                        check_eq("read_data", 32'(bus.rd_state), 32'(e.st));
                        read_cnt++;
                        last_xfer_cyc = cyc;
                    end
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic wait_done(output int dc);
        bit found;
        found = 1'b0;
        dc = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                dc = cyc;
                check_eq("busy_with_done", 32'(busy), 32'd0);
                break;
            end
        end
        if (!found) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_cmd"}, 32'(bus.cmd), 32'(`PE_CMD_NOP));
        check_eq({tag, "_sel"}, {8'd0, bus.rsel_i, bus.csel_i, bus.rsel_o, bus.csel_o, 8'd0}, 32'd0);
        check_eq({tag, "_load_ready"}, 32'(bus.load_ready), 32'd0);
        check_eq({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
        check_eq({tag, "_gen_count"}, 32'(gen_count), 32'd0);
        check_eq({tag, "_stable"}, 32'(stable), 32'd0);
    endtask

    task automatic do_load(input logic [15:0] pat, input bit with_run);
        int k, last_cyc, dc;
        write_cnt = 0;
        proc_cnt  = 0;
        op_load   = 1'b1;
        op_run    = with_run;
        num_gens  = 16'd5;
        @(posedge clk); #1;
        op_load = 1'b0;
        op_run  = 1'b0;
        k = 0;
        last_cyc = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (k % 3 == 2) begin
                bus.load_valid = 1'b0;
                @(negedge clk);
                check_eq("load_ready_stall", 32'(bus.load_ready), 32'd1);
                check_eq("load_stall_cmd", 32'(bus.cmd), 32'(`PE_CMD_NOP));
                @(posedge clk); #1;
                k++;
            end
            bus.load_valid = 1'b1;
            bus.load_state = `PE_STATE_BITS'(pat[i]);
            load_q.push_back('{i / COLS, i % COLS, pat[i]});
            last_cyc = cyc;
            @(posedge clk); #1;
            k++;
        end
        bus.load_valid = 1'b0;
        wait_done(dc);
        check_eq("load_done_latency", 32'(dc - last_cyc), 32'd1);
        check_eq("load_write_count", 32'(write_cnt), 32'd16);
        check_eq("load_queue_empty", 32'(load_q.size()), 32'd0);
        if (with_run) check_eq("load_wins_no_process", 32'(proc_cnt), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [15:0] pat);
        int dc;
        read_cnt = 0;
        for (int unsigned i = 0; i < 16; i++) read_q.push_back('{i / COLS, i % COLS, pat[i]});
        op_read = 1'b1;
        @(posedge clk); #1;
        op_read = 1'b0;
        for (int i = 0; i < 200 && read_cnt < 16; i++) begin
            bus.rd_ready = (i % 2 == 1);
            @(posedge clk); #1;
        end
        bus.rd_ready = 1'b0;
        wait_done(dc);
        check_eq("read_done_latency", 32'(dc - last_xfer_cyc), 32'd1);
        check_eq("read_count", 32'(read_cnt), 32'd16);
        read_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic do_run(input logic [15:0] n, input int exp_proc, input int exp_gc,
                          input logic exp_st, input int exp_off, input bit poke_read);
        int st, dc;
        proc_cnt = 0;
        num_gens = n;
        op_run   = 1'b1;
        st       = cyc;
        @(posedge clk); #1;
        op_run   = 1'b0;
        num_gens = 16'hFFFF;
        if (poke_read) begin
            op_read = 1'b1;
            @(posedge clk); #1;
            op_read = 1'b0;
        end
        wait_done(dc);
        check_eq("run_done_latency", 32'(dc - st), 32'(exp_off));
        check_eq("run_process_count", 32'(proc_cnt), 32'(exp_proc));
        check_eq("run_gen_count", 32'(gen_count), 32'(exp_gc));
        check_eq("run_stable", 32'(stable), 32'(exp_st));
        @(posedge clk); #1;
        check_eq("run_gen_count_hold", 32'(gen_count), 32'(exp_gc));
        check_eq("run_stable_hold", 32'(stable), 32'(exp_st));
        check_eq("run_idle_after", 32'(busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.load_valid = 1'b0;
        bus.load_state = '0;
        bus.rd_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("idle");

        do_load(PAT_BLINK, 1'b0);
        do_read(PAT_BLINK);
        do_run(16'd4, 4, 4, 1'b0, 5, 1'b0);
        do_read(PAT_BLINK);

        // Reset while the pointer sits at cell 5 of a load.
        write_cnt = 0;
        op_load = 1'b1;
        @(posedge clk); #1;
        op_load = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1;
            bus.load_state = `PE_STATE_BITS'(1);
            load_q.push_back('{i / COLS, i % COLS, 1'b1});
            @(posedge clk); #1;
        end
        bus.load_valid = 1'b1;
        #1 rst = 1'b0;
        #1 check_idle_outputs("async_reset");
        bus.load_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_eq("partial_write_count", 32'(write_cnt), 32'd5);
        check_eq("partial_queue_empty", 32'(load_q.size()), 32'd0);
        @(posedge clk); #1;

        do_load(PAT_BLOCK, 1'b0);
        do_run(16'd10, 1, 1, 1'b1, 2, 1'b0);
        do_run(16'd0, 0, 0, 1'b0, 2, 1'b0);

        do_load(PAT_A, 1'b1);
        do_read(PAT_A);

        do_load(PAT_BLINK, 1'b0);
        do_run(16'd3, 3, 3, 1'b0, 4, 1'b1);
        @(negedge clk);
        check_eq("read_ignored_rd_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
